// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter - data-priority arbiter sharing one 1-cycle SRAM port between
//               instruction fetch and data load/store, with a fetch
//               anti-starvation streak limit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int D_STREAK_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic [3:0]    d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic [3:0]    mem_we,
  output logic [AW-3:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D_RD = 2'd2,
    OWN_D_WR = 2'd3
  } owner_e;

  localparam logic [3:0] STREAK_LIM = 4'(D_STREAK_MAX);

  owner_e        owner_q, owner_d;
  logic [3:0]    streak_q, streak_d;
  logic [DW-1:0] i_rdata_q, i_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_legal;
  logic          d_win;
  logic          i_win;
  logic          unused_i_addr_lsb;

  // Fetch PCs are always word aligned, so the byte offset carries no information.
  assign unused_i_addr_lsb = ^i_addr[1:0];

  always_comb begin
    d_legal = 1'b0;
    case (d_we)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: d_legal = 1'b1;
      4'b0011, 4'b1100:                            d_legal = ~d_addr[0];
      4'b1111:                                     d_legal = (d_addr[1:0] == 2'b00);
      default:                                     d_legal = 1'b0;
    endcase

    // Data wins unless a waiting fetch has already been passed over STREAK_LIM times.
    d_win = rst & d_req & d_legal & (~i_req | (streak_q < STREAK_LIM));
    i_win = rst & i_req & ~d_win;

    streak_d = (d_win & i_req) ? streak_q + 4'd1 : 4'd0;

    if (d_win)      owner_d = (d_we == 4'b0000) ? OWN_D_RD : OWN_D_WR;
    else if (i_win) owner_d = OWN_I;
    else            owner_d = OWN_NONE;

    i_gnt     = i_win;
    d_gnt     = d_win;
    d_err     = rst & d_req & ~d_legal;
    mem_en    = d_win | i_win;
    mem_we    = d_win ? d_we : 4'b0000;
    mem_addr  = d_win ? d_addr[AW-1:2] : (i_win ? i_addr[AW-1:2] : '0);
    mem_wdata = d_win ? d_wdata : '0;

    i_rvalid  = rst & (owner_q == OWN_I);
    d_rvalid  = rst & ((owner_q == OWN_D_RD) | (owner_q == OWN_D_WR));

    // Read data lanes only move on their own read-response cycle.
    i_rdata_d = (owner_q == OWN_I)    ? mem_rdata : i_rdata_q;
    d_rdata_d = (owner_q == OWN_D_RD) ? mem_rdata : d_rdata_q;
    i_rdata   = rst ? i_rdata_d : '0;
    d_rdata   = rst ? d_rdata_d : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      streak_q  <= 4'd0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      owner_q   <= owner_d;
      streak_q  <= streak_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter - scoreboard bench for mem_arbiter with a 1-cycle SRAM model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt, i_rvalid;
  logic [31:0] i_rdata;
  logic        d_req;
  logic [3:0]  d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_rvalid, d_err;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(32), .DW(32), .D_STREAK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  logic [31:0] tb_mem [0:1023];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we == 4'b0000) mem_rdata <= tb_mem[mem_addr[9:0]];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) tb_mem[mem_addr[9:0]][8*b +: 8] = mem_wdata[8*b +: 8];
    end
  end

  int          checks = 0;
  int          errors = 0;
  logic [31:0] i_q[$];
  logic [32:0] d_q[$];
  logic [31:0] last_d = '0;

  // Scoreboard: expected words pushed at grant from the bench's own memory, popped at rvalid.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    logic [32:0] de;
    #2;
    if (i_rvalid === 1'b1) begin
      checks++;
      if (i_q.size() == 0) begin
        errors++; $display("FAIL sb_i_unexpected: i_rvalid=1 with nothing outstanding");
      end else begin
        e = i_q.pop_front();
        if (i_rdata !== e) begin errors++; $display("FAIL sb_i_rdata: got %h want %h", i_rdata, e); end
      end
    end
    if (d_rvalid === 1'b1) begin
      checks++;
      if (d_q.size() == 0) begin
        errors++; $display("FAIL sb_d_unexpected: d_rvalid=1 with nothing outstanding");
      end else begin
        de = d_q.pop_front();
        if (de[32]) last_d = de[31:0];
        if (d_rdata !== last_d) begin errors++; $display("FAIL sb_d_rdata: got %h want %h", d_rdata, last_d); end
      end
    end
    if (i_gnt === 1'b1) i_q.push_back(tb_mem[i_addr[11:2]]);
    if (d_gnt === 1'b1) d_q.push_back({d_we == 4'b0000, tb_mem[d_addr[11:2]]});
  end

  task automatic idle();
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = '0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h100; d_wdata = 32'h55;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if ({i_gnt, d_gnt, d_err, mem_en, i_rvalid, d_rvalid} !== 6'b0) begin
        errors++; $display("FAIL reset_ctrl: got %b want 000000", {i_gnt, d_gnt, d_err, mem_en, i_rvalid, d_rvalid});
      end
      checks++;
      if (mem_we !== 4'b0 || mem_addr !== 30'h0 || mem_wdata !== 32'h0 || i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
        errors++; $display("FAIL reset_data: we=%b addr=%h wd=%h ir=%h dr=%h want all 0", mem_we, mem_addr, mem_wdata, i_rdata, d_rdata);
      end
    end
    @(negedge clk); rst = 1'b1; idle();
  endtask

  task automatic test_fetch();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      tb_mem[4] = 32'hAAAA0000 + k;
      i_req = 1'b1; i_addr = 32'h10;
      #1;
      checks++;
      if (i_gnt !== 1'b1 || mem_addr !== 30'h4 || mem_we !== 4'b0 || mem_en !== 1'b1) begin
        errors++; $display("FAIL fetch_issue%0d: gnt=%b en=%b addr=%h we=%b want 1 1 4 0", k, i_gnt, mem_en, mem_addr, mem_we);
      end
      if (k > 1) begin
        checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 32'hAAAA0000 + k - 1) begin
          errors++; $display("FAIL fetch_resp%0d: rvalid=%b data=%h want 1 %h", k, i_rvalid, i_rdata, 32'hAAAA0000 + k - 1);
        end
      end
    end
    @(negedge clk); idle(); #1;
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hAAAA0003 || mem_en !== 1'b0) begin
      errors++; $display("FAIL fetch_last: rvalid=%b data=%h en=%b want 1 aaaa0003 0", i_rvalid, i_rdata, mem_en);
    end
  endtask

  task automatic test_contention();
    tb_mem[32'h40] = 32'h12345678; tb_mem[8] = 32'hCAFE0008;
    @(negedge clk);
    i_req = 1'b1; i_addr = 32'h20; d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h100;
    #1; checks++;
    if (d_gnt !== 1'b1 || i_gnt !== 1'b0 || mem_addr !== 30'h40) begin
      errors++; $display("FAIL cont_c0: dg=%b ig=%b addr=%h want 1 0 40", d_gnt, i_gnt, mem_addr);
    end
    @(negedge clk); d_req = 1'b0; #1; checks++;
    if (i_gnt !== 1'b1 || d_rvalid !== 1'b1 || d_rdata !== 32'h12345678 || mem_addr !== 30'h8) begin
      errors++; $display("FAIL cont_c1: ig=%b drv=%b dr=%h addr=%h want 1 1 12345678 8", i_gnt, d_rvalid, d_rdata, mem_addr);
    end
    @(negedge clk); idle(); #1; checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hCAFE0008 || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL cont_c2: irv=%b ir=%h drv=%b want 1 cafe0008 0", i_rvalid, i_rdata, d_rvalid);
    end
  endtask

  task automatic test_starvation();
    logic [6:0] exp_d = 7'b1101111;  // bit k set = data grant in cycle k: D,D,D,D,I,D,D
    int nd = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h10;
      d_req = (nd < 6); d_we = 4'b0000; d_addr = 32'h100 + 4 * nd;
      #1; checks++;
      if (d_gnt !== exp_d[k] || i_gnt !== ~exp_d[k]) begin
        errors++; $display("FAIL starve_c%0d: dg=%b ig=%b want %b %b", k, d_gnt, i_gnt, exp_d[k], ~exp_d[k]);
      end
      if (d_gnt === 1'b1) nd++;
    end
    @(negedge clk); d_req = 1'b0; #1; checks++;
    if (i_gnt !== 1'b1) begin errors++; $display("FAIL starve_fetch: ig=%b want 1", i_gnt); end
    @(negedge clk); idle();
  endtask

  task automatic test_stores();
    tb_mem[32'h80] = 32'h11223344;
    @(negedge clk);
    d_req = 1'b1; d_we = 4'b0100; d_addr = 32'h202; d_wdata = 32'h00AB0000;
    #1; checks++;
    if (d_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0100 || mem_addr !== 30'h80 || mem_wdata !== 32'h00AB0000) begin
      errors++; $display("FAIL sb_issue: dg=%b en=%b we=%b addr=%h wd=%h", d_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk); d_we = 4'b1100; d_wdata = 32'hBEEF0000; #1; checks++;
    if (d_gnt !== 1'b1 || d_err !== 1'b0 || d_rvalid !== 1'b1) begin
      errors++; $display("FAIL sh_issue: dg=%b de=%b drv=%b want 1 0 1", d_gnt, d_err, d_rvalid);
    end
    @(negedge clk); d_we = 4'b1111; d_wdata = 32'h99; #1; checks++;
    if (d_err !== 1'b1 || d_gnt !== 1'b0 || mem_en !== 1'b0) begin
      errors++; $display("FAIL sw_misalign: de=%b dg=%b en=%b want 1 0 0", d_err, d_gnt, mem_en);
    end
    @(negedge clk); i_req = 1'b1; i_addr = 32'h10; #1; checks++;
    if (d_err !== 1'b1 || i_gnt !== 1'b1 || mem_en !== 1'b1 || mem_we !== 4'b0 || mem_addr !== 30'h4) begin
      errors++; $display("FAIL sw_misalign_fetch: de=%b ig=%b en=%b we=%b addr=%h", d_err, i_gnt, mem_en, mem_we, mem_addr);
    end
    @(negedge clk); i_req = 1'b0; d_we = 4'b0101; d_addr = 32'h200; #1; checks++;
    if (d_err !== 1'b1 || d_gnt !== 1'b0) begin
      errors++; $display("FAIL bad_strobe: de=%b dg=%b want 1 0", d_err, d_gnt);
    end
    @(negedge clk); d_we = 4'b0011; d_addr = 32'h201; #1; checks++;
    if (d_err !== 1'b1 || mem_en !== 1'b0) begin
      errors++; $display("FAIL sh_misalign: de=%b en=%b want 1 0", d_err, mem_en);
    end
    @(negedge clk); d_we = 4'b0000; d_addr = 32'h200; #1; checks++;
    if (d_gnt !== 1'b1 || d_err !== 1'b0) begin
      errors++; $display("FAIL lw_after_st: dg=%b de=%b want 1 0", d_gnt, d_err);
    end
    @(negedge clk); idle(); #1; checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hBEEF3344) begin
      errors++; $display("FAIL st_merge: drv=%b dr=%h want 1 beef3344", d_rvalid, d_rdata);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    d_req = 1'b1; d_we = 4'b0000; d_addr = 32'h100;
    #1; checks++;
    if (d_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt: dg=%b want 1", d_gnt); end
    @(negedge clk); rst = 1'b0; idle(); #1; checks++;
    if (d_rvalid !== 1'b0 || i_rvalid !== 1'b0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_during: drv=%b irv=%b dr=%h want 0 0 0", d_rvalid, i_rvalid, d_rdata);
    end
    d_q.delete(); last_d = '0;
    @(negedge clk); #1; checks++;
    if (d_rvalid !== 1'b0 || mem_en !== 1'b0 || d_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_after: drv=%b en=%b dr=%h want 0 0 0", d_rvalid, mem_en, d_rdata);
    end
    @(negedge clk); rst = 1'b1; i_req = 1'b1; i_addr = 32'h10; #1; checks++;
    if (i_gnt !== 1'b1 || d_rvalid !== 1'b0) begin
      errors++; $display("FAIL rmid_fetch: ig=%b drv=%b want 1 0", i_gnt, d_rvalid);
    end
    @(negedge clk); idle(); #1; checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'hAAAA0003) begin
      errors++; $display("FAIL rmid_fresp: irv=%b ir=%h want 1 aaaa0003", i_rvalid, i_rdata);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    d_req = 1'b1; d_we = 4'b1111; d_addr = 32'h300; d_wdata = 32'hDEADBEEF;
    #1; checks++;
    if (d_gnt !== 1'b1 || mem_we !== 4'b1111 || mem_addr !== 30'hC0) begin
      errors++; $display("FAIL b2b_sw: dg=%b we=%b addr=%h want 1 1111 c0", d_gnt, mem_we, mem_addr);
    end
    @(negedge clk); d_we = 4'b0000; #1; checks++;
    if (d_gnt !== 1'b1 || mem_we !== 4'b0000 || d_rvalid !== 1'b1) begin
      errors++; $display("FAIL b2b_lw: dg=%b we=%b drv=%b want 1 0000 1", d_gnt, mem_we, d_rvalid);
    end
    @(negedge clk); idle(); #1; checks++;
    if (d_rvalid !== 1'b1 || d_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL b2b_data: drv=%b dr=%h want 1 deadbeef", d_rvalid, d_rdata);
    end
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) tb_mem[a] = 32'h0;
    rst = 1'b0;
    idle();
    test_reset();
    test_fetch();
    test_contention();
    test_starvation();
    test_stores();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    #3; checks++;
    if (i_q.size() != 0 || d_q.size() != 0) begin
      errors++; $display("FAIL sb_drain: i_pending=%0d d_pending=%0d want 0 0", i_q.size(), d_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, 1-cycle-latency word SRAM between the CPU instruction-fetch port and data load/store port.
- Arbitrates per cycle, issues one access, and routes the returning read data to the winning port.
- Data requests have priority over fetches. A streak counter stops the data port from starving fetches.
- Sits between the CPU core and the unified memory macro.

Parameters:
AW, 32, address width in bits (byte address)
DW, 32, data width in bits (fixed at 32; strobes are 4 bits)
D_STREAK_MAX, 4, max consecutive data grants while a fetch is pending (range 1..15)

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-low (rst==0 resets on the clock edge)
i_req  input  1  fetch request; held with i_addr until i_gnt
i_addr  input  AW  fetch byte address
i_gnt  output  1  one-cycle pulse: fetch accepted this cycle
i_rvalid  output  1  one-cycle pulse: i_rdata valid
i_rdata  output  DW  fetched word
d_req  input  1  data request; held with d_* fields until d_gnt or d_err
d_we  input  4  byte write strobes; 0000 = read
d_addr  input  AW  data byte address
d_wdata  input  DW  store data, already lane-aligned
d_gnt  output  1  one-cycle pulse: data access accepted
d_rvalid  output  1  one-cycle pulse: read data valid, or write complete
d_rdata  output  DW  loaded word (raw; the CPU sign/zero-extends)
d_err  output  1  one-cycle pulse: misaligned access rejected
mem_en  output  1  memory access enable
mem_we  output  4  memory byte write enables
mem_addr  output  AW-2  word address
mem_wdata  output  DW  memory write data
mem_rdata  input  DW  memory read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- Reset (rst==0): all outputs 0; streak counter 0; resp_owner = NONE.
- Combinational issue, registered response. mem_en/mem_we/mem_addr/mem_wdata and i_gnt/d_gnt/d_err are decided combinationally from the requests and the current streak.
- Arbitration each cycle:
  - d_req=1 and (i_req=0 or streak < D_STREAK_MAX): grant data; streak++ if i_req=1, else streak=0.
  - Otherwise if i_req=1: grant fetch; streak=0.
  - Neither request: streak=0, mem_en=0.
- Fetch issue: mem_en=1, mem_we=0, mem_addr=i_addr[AW-1:2]. i_addr[1:0] is ignored (the CPU only issues aligned PCs).
- Data alignment check, applied before granting data:
  - Word (d_we==1111): d_addr[1:0] must be 00.
  - Half (d_we==0011/1100): d_addr[0] must be 0.
  - Byte (single-bit d_we) and read (0000): always legal.
  - Any other strobe pattern is illegal.
  - On violation: d_err=1, d_gnt=0, no memory access. The fetch may be granted in the same cycle. The streak is not incremented.
- Data issue: mem_en=1, mem_we=d_we, mem_addr=d_addr[AW-1:2], mem_wdata=d_wdata.
- Response cycle (cycle after a grant): resp_owner register records I, D_RD, D_WR or NONE.
  - I: i_rvalid=1, i_rdata=mem_rdata.
  - D_RD: d_rvalid=1, d_rdata=mem_rdata.
  - D_WR: d_rvalid=1, d_rdata holds its last value.
  - NONE: all rvalids 0.
- Fully pipelined: a new grant may issue in the same cycle as the previous response. Peak throughput is one access per cycle.
- Requester rule: after gnt, the requester may deassert or present a new request the next cycle. Fields must be stable while req=1 and no gnt.
- Simultaneous i_req and d_req with streak below the limit: data wins. Fetch waits until d_req drops or the streak reaches D_STREAK_MAX.
- Reset during an outstanding access: resp_owner clears and no rvalid is produced. Memory state of an in-flight write is undefined.
- i_rdata/d_rdata change only on their own rvalid cycle.

Test Plan:
- Fetch only: i_req=1, i_addr=0x10 for 3 cycles, mem returns 0xAAAA0001/2/3 -> i_gnt every cycle; mem_addr=0x4; i_rvalid each following cycle with matching data.
- Contention: i_req=1 and d_req=1 (read 0x100) together -> d_gnt cycle 0, i_gnt cycle 1; d_rvalid cycle 1, i_rvalid cycle 2.
- Starvation guard: d_req held for 6 reads while i_req=1, D_STREAK_MAX=4 -> grant order D,D,D,D,I,D,D; streak resets after the I grant.
- Stores:
  - SB d_we=0100, d_addr=0x202 -> mem_we=0100, mem_addr=0x80, d_gnt then d_rvalid.
  - SH d_we=1100, addr 0x202 -> accepted.
  - SW addr 0x202 -> d_err, mem_en stays 0 (or carries a concurrent fetch).
- Reset mid-access: read granted, then rst=0 on the next edge -> no d_rvalid; all outputs 0. After rst=1, a fetch is granted normally.
- Back-to-back mixed: SW 0x300 data 0xDEADBEEF, then LW 0x300 -> mem_we=1111 then 0000; d_rvalid twice; second returns 0xDEADBEEF from the memory model.
